// File: rtl/calendar.sv
// calendar: day/month/year keeper advanced on the midnight hour rollover,
// with date load, pause and per-field manual adjust, plus BCD digit outputs.
module calendar #(
   parameter int unsigned RESET_DAY   = 31,
   parameter int unsigned RESET_MONTH = 12,
   parameter int unsigned RESET_YEAR  = 24
) (
   input  logic        clk_1hz,
   input  logic        date_reset,
   input  logic [4:0]  hour_in,
   input  logic        date_pause,
   input  logic        date_set,
   input  logic [15:0] date_in,
   input  logic        day_inc,
   input  logic        day_dec,
   input  logic        month_inc,
   input  logic        month_dec,
   input  logic        year_inc,
   input  logic        year_dec,
   output logic [4:0]  day_out,
   output logic [3:0]  month_out,
   output logic [6:0]  year_out,
   output logic [3:0]  day_1s,
   output logic [3:0]  day_10s,
   output logic [3:0]  mon_1s,
   output logic [3:0]  mon_10s,
   output logic [3:0]  yr_1s,
   output logic [3:0]  yr_10s,
   output logic        new_day
);

   logic [4:0] prev_hour;
   logic       rollover;

   logic [3:0] set_month;
   logic [6:0] set_year;
   logic [4:0] set_len;
   logic [4:0] set_day;

   logic [4:0] adv_day;
   logic [3:0] adv_month;
   logic [6:0] adv_year;
   logic [4:0] cur_len;

   logic [6:0] man_year;
   logic [3:0] man_month;
   logic [4:0] man_len;
   logic [4:0] man_day;
   logic       my_btn;

   // Days in month m of year 2000+y; every multiple-of-4 year in range is leap.
   function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
      logic [4:0] len;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
         4'd2:                    len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
         default:                 len = 5'd31;
      endcase
      return len;
   endfunction

   assign rollover = (prev_hour == 5'd23) && (hour_in == 5'd0);
   assign cur_len  = month_len(month_out, year_out);

   // Clamp a loaded date into a valid calendar date.
   always_comb begin
      set_month = date_in[8:5];
      if (set_month == 4'd0 || set_month > 4'd12) set_month = 4'd1;
      set_year = date_in[15:9];
      if (set_year > 7'd99) set_year = 7'd99;
      set_len = month_len(set_month, set_year);
      set_day = date_in[4:0];
      if (set_day == 5'd0)          set_day = 5'd1;
      else if (set_day > set_len)   set_day = set_len;
   end

   // Automatic advance by one day with month and year carry.
   always_comb begin
      adv_day   = day_out + 5'd1;
      adv_month = month_out;
      adv_year  = year_out;
      if (day_out >= cur_len) begin
         adv_day = 5'd1;
         if (month_out >= 4'd12) begin
            adv_month = 4'd1;
            adv_year  = (year_out >= 7'd99) ? 7'd0 : year_out + 7'd1;
         end else begin
            adv_month = month_out + 4'd1;
         end
      end
   end

   // Manual adjust: year, then month, then day clamped or wrapped in-month.
   always_comb begin
      man_year = year_out;
      if (year_inc && !year_dec)      man_year = (year_out >= 7'd99) ? 7'd0 : year_out + 7'd1;
      else if (year_dec && !year_inc) man_year = (year_out == 7'd0) ? 7'd99 : year_out - 7'd1;

      man_month = month_out;
      if (month_inc && !month_dec)      man_month = (month_out >= 4'd12) ? 4'd1 : month_out + 4'd1;
      else if (month_dec && !month_inc) man_month = (month_out <= 4'd1) ? 4'd12 : month_out - 4'd1;

      man_len = month_len(man_month, man_year);
      my_btn  = year_inc || year_dec || month_inc || month_dec;

      man_day = day_out;
      if (my_btn) begin
         if (day_out > man_len) man_day = man_len;
      end else if (day_inc && !day_dec) begin
         man_day = (day_out >= man_len) ? 5'd1 : day_out + 5'd1;
      end else if (day_dec && !day_inc) begin
         man_day = (day_out <= 5'd1) ? man_len : day_out - 5'd1;
      end
   end

   // Date registers: reset > set > (pause ? manual : rollover).
   always_ff @(posedge clk_1hz) begin
      if (date_reset) begin
         day_out   <= 5'(RESET_DAY);
         month_out <= 4'(RESET_MONTH);
         year_out  <= 7'(RESET_YEAR);
         new_day   <= 1'b0;
         prev_hour <= '0;
      end else begin
         prev_hour <= hour_in;
         new_day   <= 1'b0;
         if (date_set) begin
            day_out   <= set_day;
            month_out <= set_month;
            year_out  <= set_year;
         end else if (date_pause) begin
            day_out   <= man_day;
            month_out <= man_month;
            year_out  <= man_year;
         end else if (rollover) begin
            day_out   <= adv_day;
            month_out <= adv_month;
            year_out  <= adv_year;
            new_day   <= 1'b1;
         end
      end
   end

   assign day_10s = 4'(day_out / 5'd10);
   assign day_1s  = 4'(day_out % 5'd10);
   assign mon_10s = 4'(month_out / 4'd10);
   assign mon_1s  = 4'(month_out % 4'd10);
   assign yr_10s  = 4'(year_out / 7'd10);
   assign yr_1s   = 4'(year_out % 7'd10);

endmodule
